spectrum_histogram: RTL and testbench
=====================================

SPECTRUM_HISTOGRAM -- requirements
Module: spectrum_histogram

Interface
REQ-001 SHALL have parameter CH_BITS, default 10, channel address width (1024 channels).
REQ-002 SHALL have parameter CNT_BITS, default 32, per-channel count width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 CLOCK_50  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_start  in  1  one-cycle pulse; begin or resume accumulation.
REQ-007 cmd_pause  in  1  one-cycle pulse; stop accepting events.
REQ-008 cmd_clear  in  1  one-cycle pulse; zero all channels.
REQ-009 event_valid  in  1  event strobe from the ADC/peak-detect stage.
REQ-010 event_channel  in  CH_BITS  channel of the event; sampled only when event_valid=1.
REQ-011 channel_address  in  CH_BITS  host read address, driven by the USB command block.
REQ-012 channel_count  out  CNT_BITS  count at channel_address.
REQ-013 running  out  1  high in RUN.
REQ-014 clearing  out  1  high in CLEAR.
REQ-015 total_events  out  CNT_BITS  events accepted since the last clear.
REQ-016 dropped_events  out  16  events presented while not in RUN.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, PAUSE, CLEAR.
REQ-018 Transitions: IDLE/PAUSE --start--> RUN; RUN --pause--> PAUSE; any state --clear--> CLEAR; CLEAR --sweep done--> IDLE.
REQ-019 Simultaneous command priority: clear > pause > start; lower-priority commands in the same cycle are ignored.
REQ-020 start and pause received during CLEAR SHALL be ignored.
REQ-021 An event SHALL be accepted only when state=RUN and event_valid=1; one event per cycle maximum.
REQ-022 Accumulation SHALL be a 2-stage read-modify-write: cycle N read of event_channel; cycle N+1 write of count+1.
REQ-023 Back-to-back events to the same channel SHALL forward the in-flight value so that no increment is lost.
REQ-024 Per-channel count SHALL saturate at 2^CNT_BITS-1.
REQ-025 total_events SHALL saturate at 2^CNT_BITS-1.
REQ-026 dropped_events SHALL saturate at 0xFFFF.
REQ-027 A pause arriving with a read-modify-write in flight SHALL let that write complete.
REQ-028 CLEAR SHALL write zero to addresses 0..2^CH_BITS-1, one per cycle, 2^CH_BITS cycles.
REQ-029 CLEAR SHALL also zero total_events and dropped_events on entry.
REQ-030 A clear issued mid-sweep SHALL restart the sweep at address 0.
REQ-031 Events arriving during CLEAR SHALL be dropped and counted (after the entry zeroing).
REQ-032 Read latency: channel_count SHALL reflect channel_address registered 2 cycles earlier, including writes committed at least 1 cycle before the read.
REQ-033 The host read port SHALL never stall the accumulate path, and the accumulate path SHALL never stall the host read port.

Reset
REQ-034 On rst, state SHALL be IDLE.
REQ-035 On rst, running=0, clearing=0, total_events=0, dropped_events=0, channel_count=0, and the pipeline SHALL be empty.
REQ-036 Histogram RAM contents are not reset; the first cmd_clear after rst initialises them.
REQ-037 rst asserted mid-sweep or mid-write SHALL abort immediately, with no write on the following cycle.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, CH_BITS/CNT_BITS defaults, and the saturation maximum constants.
REQ-039 Sub-module histo_ram SHALL provide one write port and two registered read ports (accumulate, host), built as duplicated M4K blocks.
REQ-040 All FSM, forwarding, and counter logic SHALL reside in spectrum_histogram.

Verification
REQ-041 Clear then start, then events to channel 5 on 3 consecutive cycles -> count[5]=3, total_events=3.
REQ-042 Alternating channels 7,8,7,8 back-to-back, then 1 cycle gap, then 7 -> count[7]=3, count[8]=2.
REQ-043 Preload count[9]=0xFFFFFFFE, then 3 events to channel 9 -> count[9]=0xFFFFFFFF.
REQ-044 In RUN, 1 event with pause on the same cycle, then 4 events during PAUSE -> count unchanged, dropped_events=5 (the same-cycle event is dropped because pause has priority).
REQ-045 cmd_clear at sweep address 500, with start pulsed during CLEAR -> clearing held for 1024 more cycles, then IDLE, all reads=0.
REQ-046 Set channel_address=5 while channel 5 increments -> channel_count updates 2 cycles after each committed write; rst mid-sweep -> IDLE, clearing=0 within the same cycle.

Source files
------------

// File: rtl/spectrum_histogram_pkg.sv
// Shared definitions for the spectrum histogrammer: FSM states, default
// widths and fixed saturation limits.
package spectrum_histogram_pkg;

  localparam int unsigned DEF_CH_BITS  = 10;
  localparam int unsigned DEF_CNT_BITS = 32;
  localparam int unsigned DROP_BITS    = 16;

  localparam logic [DROP_BITS-1:0]    DROP_MAX    = '1;
  localparam logic [DEF_CNT_BITS-1:0] DEF_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/histo_ram.sv
// Channel RAM: one write port feeding two identical copies so the accumulate
// and host read ports each own a registered read port and never contend.
module histo_ram
  import spectrum_histogram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_CH_BITS,
  parameter int unsigned DATA_BITS = DEF_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] acc_addr,
  output logic [DATA_BITS-1:0] acc_data,
  input  logic [ADDR_BITS-1:0] host_addr,
  output logic [DATA_BITS-1:0] host_data
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem_acc  [DEPTH];
  logic [DATA_BITS-1:0] mem_host [DEPTH];

  // Contents are deliberately not reset; a clear sweep initialises them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_acc[wr_addr]  <= wr_data;
      mem_host[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data  <= '0;
      host_data <= '0;
    end else begin
      acc_data  <= mem_acc[acc_addr];
      host_data <= mem_host[host_addr];
    end
  end

endmodule

// File: rtl/spectrum_histogram.sv
// Multichannel spectrum histogrammer: run/pause/clear control, a forwarded
// 2-stage read-modify-write accumulator and a 2-cycle host read port.
module spectrum_histogram
  import spectrum_histogram_pkg::*;
#(
  parameter int unsigned CH_BITS  = DEF_CH_BITS,
  parameter int unsigned CNT_BITS = DEF_CNT_BITS
) (
  input  logic                 CLOCK_50,
  input  logic                 rst,
  input  logic                 cmd_start,
  input  logic                 cmd_pause,
  input  logic                 cmd_clear,
  input  logic                 event_valid,
  input  logic [CH_BITS-1:0]   event_channel,
  input  logic [CH_BITS-1:0]   channel_address,
  output logic [CNT_BITS-1:0]  channel_count,
  output logic                 running,
  output logic                 clearing,
  output logic [CNT_BITS-1:0]  total_events,
  output logic [DROP_BITS-1:0] dropped_events
);

  localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
  localparam logic [CH_BITS-1:0]  LAST_ADDR = '1;

  state_t              state;
  logic [CH_BITS-1:0]  sweep_addr;
  logic [CH_BITS-1:0]  host_addr_q;
  logic                s1_valid;
  logic [CH_BITS-1:0]  s1_ch;
  logic                fwd_valid;
  logic [CH_BITS-1:0]  fwd_ch;
  logic [CNT_BITS-1:0] fwd_data;
  logic [CNT_BITS-1:0] acc_rd;

  logic                accept_c;
  logic                drop_c;
  logic [CNT_BITS-1:0] cur_c;
  logic [CNT_BITS-1:0] inc_c;
  logic                wr_en_c;
  logic [CH_BITS-1:0]  wr_addr_c;
  logic [CNT_BITS-1:0] wr_data_c;

  // Clear and pause both outrank an event presented in the same cycle.
  assign accept_c = (state == ST_RUN) && event_valid && !cmd_pause && !cmd_clear;
  assign drop_c   = event_valid && !accept_c;

  // The RAM read for stage 2 misses the write issued one cycle earlier; forward it.
  assign cur_c = (fwd_valid && (fwd_ch == s1_ch)) ? fwd_data : acc_rd;
  assign inc_c = (cur_c == CNT_MAX) ? CNT_MAX : cur_c + CNT_BITS'(1);

  assign wr_en_c   = clearing || s1_valid;
  assign wr_addr_c = clearing ? sweep_addr : s1_ch;
  assign wr_data_c = clearing ? '0 : inc_c;

  // Control FSM; running/clearing are registered alongside the state.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      running    <= 1'b0;
      clearing   <= 1'b0;
      sweep_addr <= '0;
    end else if (cmd_clear) begin
      state      <= ST_CLEAR;
      running    <= 1'b0;
      clearing   <= 1'b1;
      sweep_addr <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_PAUSE: begin
          if (cmd_start && !cmd_pause) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cmd_pause) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
        end
        ST_CLEAR: begin
          sweep_addr <= sweep_addr + CH_BITS'(1);
          if (sweep_addr == LAST_ADDR) begin
            state    <= ST_IDLE;
            clearing <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          running  <= 1'b0;
          clearing <= 1'b0;
        end
      endcase
    end
  end

  // Accumulate pipeline and host address register.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_ch       <= '0;
      fwd_valid   <= 1'b0;
      fwd_ch      <= '0;
      fwd_data    <= '0;
      host_addr_q <= '0;
    end else begin
      s1_valid    <= accept_c;
      s1_ch       <= event_channel;
      fwd_valid   <= s1_valid;
      fwd_ch      <= s1_ch;
      fwd_data    <= inc_c;
      host_addr_q <= channel_address;
    end
  end

  // Event statistics, zeroed whenever a clear is issued.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      total_events   <= '0;
      dropped_events <= '0;
    end else if (cmd_clear) begin
      total_events   <= '0;
      dropped_events <= '0;
    end else begin
      if (accept_c && (total_events != CNT_MAX))
        total_events <= total_events + CNT_BITS'(1);
      if (drop_c && (dropped_events != DROP_MAX))
        dropped_events <= dropped_events + DROP_BITS'(1);
    end
  end

  histo_ram #(
    .ADDR_BITS (CH_BITS),
    .DATA_BITS (CNT_BITS)
  ) u_ram (
    .clk       (CLOCK_50),
    .rst       (rst),
    .we        (wr_en_c),
    .wr_addr   (wr_addr_c),
    .wr_data   (wr_data_c),
    .acc_addr  (event_channel),
    .acc_data  (acc_rd),
    .host_addr (host_addr_q),
    .host_data (channel_count)
  );

endmodule

// File: tb/tb_spectrum_histogram.sv
// Self-checking bench for spectrum_histogram: directed vector table, hand
// sequences for clear/reset corners, and randomized traffic against a model.
module tb_spectrum_histogram;

  localparam int unsigned CHB  = 10;
  localparam int unsigned CNB  = 32;
  localparam int unsigned NCH  = 1024;
  localparam int unsigned CMAX = 32'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, pause, clr, ev_valid;
  logic [CHB-1:0]  ev_ch, addr;
  logic [CNB-1:0]  cnt, total;
  logic            running, clearing;
  logic [15:0]     dropped;

  logic            s_start, s_clr, s_valid;
  logic [3:0]      s_ch, s_addr, s_cnt, s_total;
  logic            s_running, s_clearing;
  logic [15:0]     s_dropped;

  spectrum_histogram dut (
    .CLOCK_50(clk), .rst(rst), .cmd_start(start), .cmd_pause(pause), .cmd_clear(clr),
    .event_valid(ev_valid), .event_channel(ev_ch), .channel_address(addr),
    .channel_count(cnt), .running(running), .clearing(clearing),
    .total_events(total), .dropped_events(dropped)
  );

  spectrum_histogram #(.CH_BITS(4), .CNT_BITS(4)) dut_small (
    .CLOCK_50(clk), .rst(rst), .cmd_start(s_start), .cmd_pause(1'b0), .cmd_clear(s_clr),
    .event_valid(s_valid), .event_channel(s_ch), .channel_address(s_addr),
    .channel_count(s_cnt), .running(s_running), .clearing(s_clearing),
    .total_events(s_total), .dropped_events(s_dropped)
  );

  always #10 clk = ~clk;

  // Behavioural reference: histogram array, counters, and mode.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_CLEAR} mstate_e;
  mstate_e     m_state;
  int unsigned m_mem [NCH];
  int unsigned m_total, m_dropped, pend_ch, exp_next, cnt_exp;
  int          clear_left;
  bit          pend_v, exp_next_ok, cnt_exp_ok, mem_known;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    string       name;
    bit          start, pause, valid;
    int unsigned ch, addr, idle;
    bit          chk;
    int unsigned e_cnt, e_total, e_drop;
    bit          e_run;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_total = 0; m_dropped = 0; pend_v = 0; clear_left = 0;
    exp_next = 0; exp_next_ok = 0; mem_known = 0;
  endtask

  // One clock edge of the reference, using the inputs held across that edge.
  task automatic model_edge();
    bit acc;
    cnt_exp = exp_next; cnt_exp_ok = exp_next_ok;
    if (pend_v && m_mem[pend_ch] != CMAX) m_mem[pend_ch] = m_mem[pend_ch] + 1;
    pend_v = 0;
    acc = (m_state == M_RUN) && ev_valid && !pause && !clr;
    if (clr) begin
      m_total = 0; m_dropped = 0; m_state = M_CLEAR; clear_left = NCH; mem_known = 0;
    end else begin
      if (acc) begin
        if (m_total != CMAX) m_total++;
        pend_v = 1; pend_ch = ev_ch;
      end else if (ev_valid && m_dropped != 16'hFFFF) m_dropped++;
      case (m_state)
        M_IDLE, M_PAUSE: if (start && !pause) m_state = M_RUN;
        M_RUN:           if (pause) m_state = M_PAUSE;
        default: begin
          clear_left--;
          if (clear_left == 0) begin
            m_state = M_IDLE; mem_known = 1;
            foreach (m_mem[i]) m_mem[i] = 0;
          end
        end
      endcase
    end
    exp_next = m_mem[addr]; exp_next_ok = mem_known && (m_state != M_CLEAR);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("running", running, m_state == M_RUN);
    check("clearing", clearing, m_state == M_CLEAR);
    check("total_events", total, m_total);
    check("dropped_events", dropped, m_dropped);
    if (cnt_exp_ok) check("channel_count", cnt, cnt_exp);
  endtask

  function automatic vec_t mk(string n, bit st, bit pa, bit v, int unsigned ch, int unsigned a,
                              int unsigned idle, bit chk, int unsigned ec, int unsigned et,
                              int unsigned ed, bit er);
    vec_t r;
    r.name = n; r.start = st; r.pause = pa; r.valid = v; r.ch = ch; r.addr = a; r.idle = idle;
    r.chk = chk; r.e_cnt = ec; r.e_total = et; r.e_drop = ed; r.e_run = er;
    return r;
  endfunction

  initial begin
    int n, bad;
    rst = 1; start = 0; pause = 0; clr = 0; ev_valid = 0; ev_ch = '0; addr = '0;
    s_start = 0; s_clr = 0; s_valid = 0; s_ch = '0; s_addr = '0;
    model_reset();

    vecs.push_back(mk("start",       1,0,0, 0,5, 0, 0, 0,0,0,0));
    vecs.push_back(mk("ev5_a",       0,0,1, 5,5, 0, 0, 0,0,0,0));
    vecs.push_back(mk("ev5_b",       0,0,1, 5,5, 0, 0, 0,0,0,0));
    vecs.push_back(mk("ev5_c",       0,0,1, 5,5, 3, 1, 3,3,0,1));
    vecs.push_back(mk("ev7_a",       0,0,1, 7,7, 0, 0, 0,0,0,0));
    vecs.push_back(mk("ev8_a",       0,0,1, 8,7, 0, 0, 0,0,0,0));
    vecs.push_back(mk("ev7_b",       0,0,1, 7,7, 0, 0, 0,0,0,0));
    vecs.push_back(mk("ev8_b",       0,0,1, 8,7, 1, 0, 0,0,0,0));
    vecs.push_back(mk("ev7_c",       0,0,1, 7,7, 3, 1, 3,8,0,1));
    vecs.push_back(mk("read8",       0,0,0, 0,8, 2, 1, 2,8,0,1));
    vecs.push_back(mk("ev_pause",    0,1,1, 5,5, 0, 0, 0,0,0,0));
    vecs.push_back(mk("paused_ev1",  0,0,1, 5,5, 0, 0, 0,0,0,0));
    vecs.push_back(mk("paused_ev2",  0,0,1, 5,5, 0, 0, 0,0,0,0));
    vecs.push_back(mk("paused_ev3",  0,0,1, 5,5, 0, 0, 0,0,0,0));
    vecs.push_back(mk("paused_ev4",  0,0,1, 5,5, 2, 1, 3,8,5,0));
    vecs.push_back(mk("resume",      1,0,0, 0,5, 0, 0, 0,0,0,0));
    vecs.push_back(mk("ev5_inflight",0,0,1, 5,5, 0, 0, 0,0,0,0));
    vecs.push_back(mk("pause_rmw",   0,1,0, 0,5, 3, 1, 4,9,5,0));

    repeat (2) @(posedge clk);
    #1;
    check("reset running", running, 0);
    check("reset clearing", clearing, 0);
    check("reset total", total, 0);
    check("reset dropped", dropped, 0);
    check("reset count", cnt, 0);
    rst = 0;

    // Initial clear sweep.
    clr = 1; tick(); clr = 0;
    check("clear entry", clearing, 1);
    repeat (NCH) tick();
    check("clear done", clearing, 0);

    foreach (vecs[i]) begin
      start = vecs[i].start; pause = vecs[i].pause; ev_valid = vecs[i].valid;
      ev_ch = CHB'(vecs[i].ch); addr = CHB'(vecs[i].addr);
      tick();
      start = 0; pause = 0; ev_valid = 0;
      repeat (vecs[i].idle) tick();
      if (vecs[i].chk) begin
        check({vecs[i].name, " count"}, cnt, vecs[i].e_cnt);
        check({vecs[i].name, " total"}, total, vecs[i].e_total);
        check({vecs[i].name, " dropped"}, dropped, vecs[i].e_drop);
        check({vecs[i].name, " running"}, running, vecs[i].e_run);
      end
    end

    // Host view of channel 5 around one committed write.
    start = 1; tick(); start = 0;
    ev_valid = 1; ev_ch = CHB'(5); tick(); ev_valid = 0;
    check("lat accept edge", cnt, 4);
    tick();
    check("lat write edge", cnt, 4);
    tick();
    check("lat visible", cnt, 5);

    // Randomized traffic on a small channel set to exercise forwarding.
    for (int c = 0; c < 2000; c++) begin
      start = ($urandom_range(0, 99) < 4);
      pause = ($urandom_range(0, 99) < 3);
      ev_valid = ($urandom_range(0, 99) < 70);
      ev_ch = ($urandom_range(0, 3) == 0) ? CHB'($urandom_range(0, NCH-1)) : CHB'($urandom_range(0, 7));
      addr = CHB'($urandom_range(0, 7));
      tick();
    end
    start = 0; pause = 0; ev_valid = 0;

    // Clear restarted mid-sweep, with a start ignored during CLEAR.
    clr = 1; tick(); clr = 0;
    repeat (500) tick();
    clr = 1; tick(); clr = 0;
    n = 0;
    while (clearing && n < 2000) begin
      if (n == 10) start = 1;
      tick();
      start = 0;
      n++;
    end
    check("restart clear cycles", n, NCH);
    check("after clear running", running, 0);
    bad = 0;
    for (int i = 0; i <= NCH; i++) begin
      if (i < NCH) addr = CHB'(i);
      tick();
      if (i >= 1 && cnt != 0) bad++;
    end
    check("all channels zero", bad, 0);

    // Asynchronous reset in the middle of a sweep.
    clr = 1; tick(); clr = 0;
    repeat (100) tick();
    rst = 1;
    #2;
    check("rst mid-sweep clearing", clearing, 0);
    check("rst mid-sweep running", running, 0);
    check("rst mid-sweep count", cnt, 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    tick();

    // Saturation on a narrow instance: preload to max-1, then three more.
    s_clr = 1; tick(); s_clr = 0;
    repeat (20) tick();
    check("small clear done", s_clearing, 0);
    s_start = 1; tick(); s_start = 0;
    check("small running", s_running, 1);
    s_ch = 4'd9; s_addr = 4'd9; s_valid = 1;
    repeat (14) tick();
    s_valid = 0;
    repeat (3) tick();
    check("small preload count", s_cnt, 14);
    check("small preload total", s_total, 14);
    s_valid = 1;
    repeat (3) tick();
    s_valid = 0;
    repeat (3) tick();
    check("small sat count", s_cnt, 15);
    check("small sat total", s_total, 15);
    check("small dropped", s_dropped, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
